// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and sizes for the fetch sequencer
package fetch_pkg;

   localparam int PC_W      = 16;
   localparam int INST_W    = 16;
   localparam int BUF_DEPTH = 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/fetch_buf.sv
// rtl/fetch_buf.sv - two-entry {pc, instr} prefetch FIFO with flush
module fetch_buf
   import fetch_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push,
   input  logic [PC_W-1:0]   push_pc,
   input  logic [INST_W-1:0] push_data,
   input  logic              pop,
   input  logic              flush,
   output logic [1:0]        count,
   output logic [PC_W-1:0]   head_pc,
   output logic [INST_W-1:0] head_data
);

   logic [PC_W-1:0]   pc0, pc1;
   logic [INST_W-1:0] d0, d1;
   logic [1:0]        cnt;
   logic              pop_eff;
   logic [1:0]        slot;
   logic [1:0]        cnt_nxt;

   // Pop only removes a real entry; the push slot is computed after the pop shifts the queue.
   always_comb begin
      pop_eff = pop && (cnt != 2'd0);
      slot    = cnt - {1'b0, pop_eff};
      cnt_nxt = cnt + {1'b0, push} - {1'b0, pop_eff};
   end

   // Entry 0 is always the head; a pop shifts entry 1 down, a push fills the first free slot.
   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         cnt <= 2'd0;
         pc0 <= '0;
         pc1 <= '0;
         d0  <= '0;
         d1  <= '0;
      end else begin
         if (pop_eff) begin
            pc0 <= pc1;
            d0  <= d1;
         end
         if (push) begin
            if (slot == 2'd0) begin
               pc0 <= push_pc;
               d0  <= push_data;
            end else begin
               pc1 <= push_pc;
               d1  <= push_data;
            end
         end
         cnt <= cnt_nxt;
      end
   end

   assign count     = cnt;
   assign head_pc   = pc0;
   assign head_data = d0;

endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - PC, fetch FSM and optional bound check (FETCH_BOUND_CHECK_EN)
module fetch_ctrl
   import fetch_pkg::*;
#(
   parameter logic [PC_W-1:0] RESET_PC   = 16'h0000,
   parameter int              IMEM_DEPTH = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic [PC_W-1:0]   imem_addr,
   input  logic [INST_W-1:0] imem_data,
   output logic              inst_valid,
   input  logic              inst_ready,
   output logic [INST_W-1:0] inst_data,
   output logic [PC_W-1:0]   inst_pc,
   input  logic              redirect_valid,
   input  logic [PC_W-1:0]   redirect_pc,
   output logic              busy,
   output logic              fetch_fault
);

   fetch_state_t    state, state_nxt;
   logic [PC_W-1:0] pc;
   logic [1:0]      buf_count;
   logic            pop;
   logic            space;
   logic            fetch;
   logic            fault_cond;

`ifdef FETCH_BOUND_CHECK_EN
   localparam logic [PC_W:0] DEPTH_X = (PC_W+1)'(IMEM_DEPTH);
   assign fault_cond  = (state == RUN) && ({1'b0, pc} >= DEPTH_X);
   assign fetch_fault = (state == HALT);
`else
   logic unused_depth;
   assign unused_depth = (IMEM_DEPTH != 0);
   assign fault_cond   = 1'b0;
   assign fetch_fault  = 1'b0;
`endif

   assign pop   = inst_valid && inst_ready;
   assign space = (buf_count < 2'(BUF_DEPTH)) || pop;

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next state and fetch decision; a redirect always wins over fetch and fault.
   always_comb begin
      state_nxt = state;
      fetch     = 1'b0;
      case (state)
         IDLE: if (start) state_nxt = RUN;
         RUN: begin
            if (!redirect_valid) begin
               if (fault_cond) state_nxt = HALT;
               else            fetch     = space;
            end
         end
         HALT: if (redirect_valid) state_nxt = RUN;
         default: state_nxt = IDLE;
      endcase
   end

   // Program counter: redirect loads the target in any state, fetch advances with 16-bit wrap.
   always_ff @(posedge clk) begin
      if (!rst_n)              pc <= RESET_PC;
      else if (redirect_valid) pc <= redirect_pc;
      else if (fetch)          pc <= pc + 16'd1;
   end

   fetch_buf u_buf (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (fetch),
      .push_pc   (pc),
      .push_data (imem_data),
      .pop       (pop),
      .flush     (redirect_valid),
      .count     (buf_count),
      .head_pc   (inst_pc),
      .head_data (inst_data)
   );

   assign imem_addr  = pc;
   assign inst_valid = (buf_count != 2'd0);
   assign busy       = (state == RUN);

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch sequencer for the 16-bit single-cycle datapath. Owns the program counter, drives the combinational-read instruction memory address, and captures one word per cycle into a 2-entry prefetch buffer. Instructions go to decode over a valid/ready handshake. Accepts branch/BNE redirects from execute, flushing stale prefetches.

## Interface
- `RESET_PC`, 16'h0000, PC loaded on reset.
- `IMEM_DEPTH`, 16, number of instruction-memory words; used by the bound check.
- `clk` input 1, single clock, rising edge.
- `rst_n` input 1, reset, synchronous, active-low.
- `start` input 1, one-cycle pulse; leaves IDLE.
- `imem_addr` output 16, word address to instruction memory; always equals PC register.
- `imem_data` input 16, instruction word; combinational from `imem_addr` in the same cycle.
- `inst_valid` output 1, buffer head valid.
- `inst_ready` input 1, decode accepts head.
- `inst_data` output 16, head instruction.
- `inst_pc` output 16, head PC.
- `redirect_valid` input 1, branch taken this cycle.
- `redirect_pc` input 16, branch target.
- `busy` output 1, state is RUN.
- `fetch_fault` output 1, PC out of bounds (macro-dependent).

## Operation
- States: IDLE, RUN, HALT. Reset puts the block in IDLE.
- IDLE to RUN on `start`. RUN to HALT on a bound violation. HALT to RUN on `redirect_valid`. `start` is ignored outside IDLE.
- Word addressing: the PC increments by 1. Arithmetic is 16-bit, and PC 16'hFFFF wraps to 0.
- Fetch condition: state RUN, no redirect, and the buffer has space. Space means count < 2, or count == 2 with a pop this cycle.
  - On fetch, {pc, imem_data} is enqueued and `pc <= pc + 1`.
  - Without fetch, `pc` holds and `imem_addr` is stable.
- Pop: `inst_valid && inst_ready`. The head advances. `inst_data` and `inst_pc` hold while valid and not ready.
- Redirect has priority over fetch. The buffer is flushed and `pc <= redirect_pc`. Nothing is enqueued that cycle.
  - A pop in the same cycle counts as consumed by decode.
- Redirect in IDLE loads the PC only and stays in IDLE.
- Buffer order is FIFO, with no loss or duplication under any ready pattern.

## Timing
- Reset values:
  - `inst_valid`=0, `inst_data`=0, `inst_pc`=0
  - `imem_addr`=RESET_PC, `busy`=0, `fetch_fault`=0
  - buffer empty
- Reset asserted mid-operation overrides everything at the next edge. All in-flight entries are discarded.
- `start` sampled at edge N: RUN from N+1. First fetch occurs in cycle N+1. `inst_valid`=1 from N+2.
- Steady state: 1 instruction per cycle with `inst_ready` held high.
- Fetch-to-valid latency: 1 cycle.
- Redirect sampled at edge R: `inst_valid`=0 in cycle R+1 while the target is fetched. Target is valid at R+2 (redirect bubble is 2 cycles).
- Full buffer (2 entries) with `inst_ready`=0: fetch stalls and the PC freezes. Fetch resumes in the same cycle `inst_ready` rises.

## Configuration
- Macro: `FETCH_BOUND_CHECK_EN`.
- Defined:
  - In RUN with `pc >= IMEM_DEPTH`, no fetch occurs. Next state is HALT and `fetch_fault`=1 from the next cycle.
  - Buffered entries still drain.
  - `fetch_fault` clears on the redirect edge out of HALT.
- Undefined:
  - No check is made, and HALT is unreachable.
  - `fetch_fault` is tied 0.
  - The address passes through unchanged.

## Structure
- `fetch_pkg`: state enum (IDLE/RUN/HALT), `PC_W`=16, `INST_W`=16, `BUF_DEPTH`=2.
- Sub-module `fetch_buf`: 2-entry {pc, instr} FIFO. It has push, pop, flush, count, and head outputs, and uses the same `clk`/`rst_n`.
- `fetch_ctrl` keeps the PC, the FSM, and the bound check.

## Test plan
- Basic run: memory loaded with words 16'h0000, 16'h1000, 16'h2000, 16'h6000, 16'h7000, 16'h8000, 16'hA000, 16'hE000 at addresses 0–7; `start` pulse, `inst_ready`=1 → `inst_pc` 0..7 on consecutive cycles with matching data; first valid 2 cycles after `start`.
- Backpressure: `inst_ready`=0 for 5 cycles from the first valid → head stays pc0/16'h0000; `imem_addr` freezes at 2. On release, pcs 0,1,2,3 are delivered in order with no gaps or duplicates.
- Redirect flush: buffer holds pc2 and pc3; `redirect_valid` with `redirect_pc`=5 → pc2 and pc3 are never presented; `inst_valid`=0 for one cycle; next head is pc5/16'h8000.
- Redirect plus pop: a pop and a redirect to 0 in the same cycle → the popped entry is counted once; the next head is pc0.
- Bound check (macro defined, `IMEM_DEPTH`=16): run from 0 with ready high → last delivered pc15; `fetch_fault`=1 and `busy`=0 after `imem_addr` reaches 16; a redirect to 0 clears the fault and resumes at pc0.
- Reset mid-run: buffer full when `rst_n` drops → next cycle shows all reset values and IDLE; `start` restarts at RESET_PC.
